// File: rtl/ofdm_cp_inserter_if.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_cp_inserter_if
// Description : Avalon-ST style streaming bundle (data, valid, ready, sop, eop)
//               used for the input and output ports of the CP inserter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ofdm_cp_inserter_if #(
    parameter int DATA_W = 34
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              startofpacket;
    logic              endofpacket;

    // Source side: drives the payload, observes backpressure.
    modport master (
        output data,
        output valid,
        output startofpacket,
        output endofpacket,
        input  ready
    );

    // Sink side: observes the payload, drives backpressure.
    modport slave (
        input  data,
        input  valid,
        input  startofpacket,
        input  endofpacket,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/ofdm_cp_inserter.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_cp_inserter
// Description : Captures N_FFT-sample OFDM symbols into a ping-pong buffer and
//               replays each as CP_LEN cyclic-prefix samples followed by the
//               full body, as one Avalon-ST packet. Words pass unmodified.
// Revision    : 1.0 - initial release
// ============================================================================
module ofdm_cp_inserter #(
    parameter int N_FFT  = 64,
    parameter int CP_LEN = 16,
    parameter int DATA_W = 34
) (
    input  logic               clock_clk,
    input  logic               reset_reset_n,
    ofdm_cp_inserter_if.slave  asi_in0,
    ofdm_cp_inserter_if.master aso_out0,
    output logic [15:0]        drop_count
);

    localparam int AW = $clog2(N_FFT);
    localparam logic [AW-1:0] c_last_idx = AW'(N_FFT - 1);
    localparam logic [AW-1:0] c_cp_last  = AW'(CP_LEN - 1);
    localparam logic [AW-1:0] c_cp_base  = AW'(N_FFT - CP_LEN);

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_t;

    // Two banks of N_FFT words; bank select is the address MSB.
    logic [DATA_W-1:0] r_mem [0:2*N_FFT-1];

    logic        r_in_en;
    logic [1:0]  r_full;
    logic        r_wr_bank;
    logic        r_rd_bank;

    wr_state_t   r_wr_state, w_wr_state_nx;
    logic [AW-1:0] r_wr_cnt, w_wr_cnt_nx;
    logic        w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic        w_wr_done;
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    rd_state_t   r_rd_state, w_rd_state_nx;
    logic [AW-1:0] r_rd_cnt, w_rd_cnt_nx;
    logic [AW-1:0] w_rd_addr;
    logic        w_emit;
    logic        w_sop;
    logic        w_eop;
    logic        w_rd_free;
    logic        w_load;
    logic [DATA_W-1:0] w_rd_data;

    logic [DATA_W-1:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_sop;
    logic        r_out_eop;

    logic        w_in_ready;
    logic        w_in_xfer;

    // Input is accepted only once out of reset and while the write bank is free.
    assign w_in_ready = r_in_en && !r_full[r_wr_bank];
    assign w_in_xfer  = asi_in0.valid && w_in_ready;
    assign asi_in0.ready = w_in_ready;

    // Holds ready low for the first cycle after reset release.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_in_en <= 1'b0;
        else                r_in_en <= 1'b1;
    end

    // Write FSM next state: validates symbol framing while filling the bank.
    always_comb begin
        w_wr_state_nx = r_wr_state;
        w_wr_cnt_nx   = r_wr_cnt;
        w_wr_en       = 1'b0;
        w_wr_addr     = '0;
        w_wr_done     = 1'b0;
        w_drop        = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_in_xfer && asi_in0.startofpacket) begin
                    if (asi_in0.endofpacket) begin
                        w_drop = 1'b1;
                    end else begin
                        w_wr_en       = 1'b1;
                        w_wr_cnt_nx   = AW'(1);
                        w_wr_state_nx = WR_FILL;
                    end
                end
            end
            WR_FILL: begin
                if (w_in_xfer) begin
                    if (asi_in0.startofpacket) begin
                        // A new sop aborts the partial symbol; a one-sample
                        // sop+eop packet is itself malformed and ends the fill.
                        w_drop = 1'b1;
                        if (asi_in0.endofpacket) begin
                            w_wr_state_nx = WR_IDLE;
                        end else begin
                            w_wr_en     = 1'b1;
                            w_wr_cnt_nx = AW'(1);
                        end
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_wr_cnt;
                        if (r_wr_cnt == c_last_idx) begin
                            w_wr_state_nx = WR_IDLE;
                            if (asi_in0.endofpacket) w_wr_done = 1'b1;
                            else                     w_drop    = 1'b1;
                        end else if (asi_in0.endofpacket) begin
                            w_drop        = 1'b1;
                            w_wr_state_nx = WR_IDLE;
                        end else begin
                            w_wr_cnt_nx = r_wr_cnt + AW'(1);
                        end
                    end
                end
            end
            default: w_wr_state_nx = WR_IDLE;
        endcase
    end

    // Write FSM state, bank pointer and saturating drop counter.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_state <= WR_IDLE;
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_state <= w_wr_state_nx;
            r_wr_cnt   <= w_wr_cnt_nx;
            if (w_wr_done) r_wr_bank <= ~r_wr_bank;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Sample storage; contents are don't-care until a bank is marked full.
    always_ff @(posedge clock_clk) begin
        if (w_wr_en) r_mem[{r_wr_bank, w_wr_addr}] <= asi_in0.data;
    end

    // Bank-full flags: writer sets its bank, reader clears its bank. The two
    // never address the same bank in the same cycle.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_full <= 2'b00;
        end else begin
            if (w_wr_done) r_full[r_wr_bank] <= 1'b1;
            if (w_rd_free) r_full[r_rd_bank] <= 1'b0;
        end
    end

    // The output register accepts a new word when empty or being drained.
    assign w_load    = !r_out_valid || aso_out0.ready;
    assign w_rd_data = r_mem[{r_rd_bank, w_rd_addr}];

    // Read FSM next state: sequences CP then body, advancing only on load.
    always_comb begin
        w_rd_state_nx = r_rd_state;
        w_rd_cnt_nx   = r_rd_cnt;
        w_rd_addr     = '0;
        w_emit        = 1'b0;
        w_sop         = 1'b0;
        w_eop         = 1'b0;
        w_rd_free     = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_rd_state_nx = RD_CP;
                    w_rd_cnt_nx   = '0;
                end
            end
            RD_CP: begin
                w_rd_addr = c_cp_base + r_rd_cnt;
                if (w_load) begin
                    w_emit = 1'b1;
                    w_sop  = (r_rd_cnt == '0);
                    if (r_rd_cnt == c_cp_last) begin
                        w_rd_state_nx = RD_BODY;
                        w_rd_cnt_nx   = '0;
                    end else begin
                        w_rd_cnt_nx = r_rd_cnt + AW'(1);
                    end
                end
            end
            RD_BODY: begin
                w_rd_addr = r_rd_cnt;
                if (w_load) begin
                    w_emit = 1'b1;
                    if (r_rd_cnt == c_last_idx) begin
                        // Last word is in the output register: release the
                        // bank and chain straight into the next symbol if ready.
                        w_eop       = 1'b1;
                        w_rd_free   = 1'b1;
                        w_rd_cnt_nx = '0;
                        w_rd_state_nx = r_full[~r_rd_bank] ? RD_CP : RD_IDLE;
                    end else begin
                        w_rd_cnt_nx = r_rd_cnt + AW'(1);
                    end
                end
            end
            default: w_rd_state_nx = RD_IDLE;
        endcase
    end

    // Read FSM state, read counter and bank pointer.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rd_state <= RD_IDLE;
            r_rd_cnt   <= '0;
            r_rd_bank  <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nx;
            r_rd_cnt   <= w_rd_cnt_nx;
            if (w_rd_free) r_rd_bank <= ~r_rd_bank;
        end
    end

    // Output pipeline register; held stable while valid and not ready.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_emit;
            r_out_sop   <= w_sop;
            r_out_eop   <= w_eop;
            if (w_emit) r_out_data <= w_rd_data;
        end
    end

    assign aso_out0.data          = r_out_data;
    assign aso_out0.valid         = r_out_valid;
    assign aso_out0.startofpacket = r_out_sop;
    assign aso_out0.endofpacket   = r_out_eop;
    assign drop_count             = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_cp_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofdm_cp_inserter
// Description : Scoreboard bench for ofdm_cp_inserter. Good symbols push their
//               80-word expected packet when issued; a monitor pops on output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofdm_cp_inserter;
    localparam int N  = 64;
    localparam int CP = 16;
    localparam int DW = 34;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ofdm_cp_inserter_if #(.DATA_W(DW)) in_if ();
    ofdm_cp_inserter_if #(.DATA_W(DW)) out_if ();
    logic [15:0] drop_count;

    ofdm_cp_inserter #(.N_FFT(N), .CP_LEN(CP), .DATA_W(DW)) dut (
        .clock_clk     (clk),
        .reset_reset_n (rst_n),
        .asi_in0       (in_if),
        .aso_out0      (out_if),
        .drop_count    (drop_count)
    );

    int errors = 0;
    int checks = 0;
    logic [DW+1:0] exp_q [$];
    int   xfer_cnt  = 0;
    int   rdy_mode  = 0;
    logic rdy_fixed = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Symbol id in the real field, sample index in the low bits.
    function automatic logic [DW-1:0] mk(input int id, input int idx);
        return (DW'(id) << 20) | DW'(idx);
    endfunction

    // Expected packet: last CP samples with sop on the first, then full body.
    task automatic push_symbol(input int id);
        for (int j = 0; j < CP; j++) exp_q.push_back({mk(id, N - CP + j), (j == 0), 1'b0});
        for (int j = 0; j < N; j++)  exp_q.push_back({mk(id, j), 1'b0, (j == N - 1)});
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic sop, input logic eop);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_if.data          = d;
        in_if.startofpacket = sop;
        in_if.endofpacket   = eop;
        in_if.valid         = 1'b1;
        do begin
            @(negedge clk);
            acc = in_if.ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 5000);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0, expected ready=1 within 5000 cycles");
        end
        in_if.valid         = 1'b0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket   = 1'b0;
    endtask

    task automatic send_good(input int id);
        push_symbol(id);
        for (int i = 0; i < N; i++) send_word(mk(id, i), (i == 0), (i == N - 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Downstream ready: fixed level or 50% random, updated just after each edge.
    always @(posedge clk) begin
        #1;
        out_if.ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Monitor: pops and compares on every transfer, checks hold under backpressure.
    logic          hold_pend = 1'b0;
    logic [DW+1:0] hold_val;
    logic [DW+1:0] mon_word;
    logic [DW+1:0] mon_exp;
    always @(negedge clk) begin
        mon_word = {out_if.data, out_if.startofpacket, out_if.endofpacket};
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(out_if.valid), 64'd1);
                check("hold_word", 64'(mon_word), 64'(hold_val));
            end
            hold_pend = 1'b0;
            if (out_if.valid) begin
                if (!out_if.ready) begin
                    hold_pend = 1'b1;
                    hold_val  = mon_word;
                end else begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got word 0x%0h, expected no transfer", mon_word);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("out_word", 64'(mon_word), 64'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        int vcnt;
        in_if.valid         = 1'b0;
        in_if.data          = '0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket   = 1'b0;
        out_if.ready        = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_if.valid), 64'd0);
        check("rst_sop", 64'(out_if.startofpacket), 64'd0);
        check("rst_eop", 64'(out_if.endofpacket), 64'd0);
        check("rst_data", 64'(out_if.data), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_in_ready", 64'(in_if.ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", 64'(in_if.ready), 64'd0);
        @(negedge clk);
        check("ready_second_cycle", 64'(in_if.ready), 64'd1);
        @(posedge clk);
        #1;

        // One symbol, output always ready, latency of first valid
        rdy_fixed = 1'b1;
        send_good(1);
        @(negedge clk);
        check("latency_c0_valid", 64'(out_if.valid), 64'd0);
        @(negedge clk);
        check("latency_c1_valid", 64'(out_if.valid), 64'd0);
        @(negedge clk);
        check("latency_c2_valid", 64'(out_if.valid), 64'd1);
        check("latency_c2_sop", 64'(out_if.startofpacket), 64'd1);
        wait_drain();

        // Back-to-back symbols: fill both banks, then drain contiguously
        rdy_fixed = 1'b0;
        @(posedge clk);
        #2;
        send_good(2);
        send_good(3);
        @(negedge clk);
        check("in_ready_both_full", 64'(in_if.ready), 64'd0);
        rdy_fixed = 1'b1;
        fork
            send_good(4);
            begin
                int gaps;
                gaps = 0;
                for (int i = 0; i < 3 * (N + CP); i++) begin
                    @(negedge clk);
                    if (!(out_if.valid && out_if.ready)) gaps++;
                end
                check("contiguous_240_gaps", 64'(gaps), 64'd0);
            end
        join
        wait_drain();

        // Random backpressure
        rdy_mode = 1;
        send_good(5);
        send_good(6);
        wait_drain();
        rdy_mode  = 0;
        rdy_fixed = 1'b1;

        // Early eop at index 40, then a good symbol
        for (int i = 0; i < 41; i++) send_word(mk(20, i), (i == 0), (i == 40));
        send_good(7);
        wait_drain();
        check("drop_early_eop", 64'(drop_count), 64'd1);

        // sop at index 30 restarts the fill
        for (int i = 0; i < 30; i++) send_word(mk(21, i), (i == 0), 1'b0);
        send_good(8);
        wait_drain();
        check("drop_mid_sop", 64'(drop_count), 64'd2);

        // Words without sop are ignored; sop+eop on one sample is dropped
        for (int i = 0; i < 3; i++) send_word(mk(22, i), 1'b0, 1'b0);
        send_word(mk(23, 0), 1'b1, 1'b1);
        @(negedge clk);
        check("drop_sop_eop", 64'(drop_count), 64'd3);
        @(posedge clk);
        #1;

        // Index N-1 without eop is dropped
        for (int i = 0; i < N; i++) send_word(mk(24, i), (i == 0), 1'b0);
        send_good(9);
        wait_drain();
        check("drop_missing_eop", 64'(drop_count), 64'd4);

        // Reset in the middle of an output packet
        base = xfer_cnt;
        send_good(10);
        n = 0;
        while (xfer_cnt < base + 20 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("midpkt_reached", 64'(xfer_cnt >= base + 20), 64'd1);
        #1;
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(out_if.valid), 64'd0);
        check("midrst_sop_eop", 64'({out_if.startofpacket, out_if.endofpacket}), 64'd0);
        check("midrst_data", 64'(out_if.data), 64'd0);
        check("midrst_drop", 64'(drop_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_if.valid) vcnt++;
        end
        check("no_output_after_reset", 64'(vcnt), 64'd0);
        @(posedge clk);
        #1;
        send_good(11);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
